// File: rtl/rs232_rx_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rs232_pkg : 8N1 frame constants and FSM encoding shared by the   |
// |             RS232 receiver and transmitter.                      |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
package rs232_pkg;

   localparam int   DATA_BITS   = 8;
   localparam int   START_BITS  = 1;
   localparam int   STOP_BITS   = 1;
   localparam int   FRAME_BITS  = START_BITS + DATA_BITS + STOP_BITS;
   localparam int   IDX_W       = $clog2(DATA_BITS);

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_START = 3'd1;
   localparam state_t ST_DATA  = 3'd2;
   localparam state_t ST_STOP  = 3'd3;
   localparam state_t ST_BREAK = 3'd4;

endpackage
`default_nettype wire

// File: rtl/rs232_rx_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rs232_sync : two-flop synchronizer, resets to the idle level (1).|
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
module rs232_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= 1'b1;
         r_q    <= 1'b1;
      end else begin
         r_meta <= d;
         r_q    <= r_meta;
      end
   end

   assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/rs232_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rs232_rx : 8N1 UART receiver, mid-bit sampling, framing errors.  |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module rs232_rx
   import rs232_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] dato,
   output logic       dv,
   output logic       ferr,
   output logic       busy
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0]    c_half_last = CW'(H - 1);
   localparam logic [CW-1:0]    c_bit_last  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(DATA_BITS - 1);

   state_t               r_state;
   state_t               w_next;
   logic [CW-1:0]        r_cnt;
   logic [IDX_W-1:0]     r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_dato;
   logic                 r_dv;
   logic                 r_ferr;

   logic                 w_rx_s;
   logic                 w_cnt_half;
   logic                 w_cnt_bit;
   logic                 w_sample;
   logic                 w_shift_en;
   logic                 w_dv_set;
   logic                 w_ferr_set;
   logic                 w_busy;

   rs232_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (w_rx_s)
   );

   assign w_cnt_half = (r_cnt == c_half_last);
   assign w_cnt_bit  = (r_cnt == c_bit_last);

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_rx_s == START_LEVEL) w_next = ST_START;
         ST_START: if (w_cnt_half) w_next = (w_rx_s == START_LEVEL) ? ST_DATA : ST_IDLE;
         ST_DATA:  if (w_cnt_bit && (r_idx == c_idx_last)) w_next = ST_STOP;
         ST_STOP:  if (w_cnt_bit) w_next = (w_rx_s == STOP_LEVEL) ? ST_IDLE : ST_BREAK;
         ST_BREAK: if (w_rx_s == IDLE_LEVEL) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_sample   = 1'b0;
      w_shift_en = 1'b0;
      w_dv_set   = 1'b0;
      w_ferr_set = 1'b0;
      w_busy     = (r_state != ST_IDLE);
      case (r_state)
         ST_START: w_sample = w_cnt_half;
         ST_DATA: begin
            w_sample   = w_cnt_bit;
            w_shift_en = w_cnt_bit;
         end
         ST_STOP: begin
            w_sample   = w_cnt_bit;
            w_dv_set   = w_cnt_bit && (w_rx_s == STOP_LEVEL);
            w_ferr_set = w_cnt_bit && (w_rx_s != STOP_LEVEL);
         end
         default: ;
      endcase
   end

   // The counter restarts at every sample point, so each bit is timed from the last sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_dato  <= '0;
         r_dv    <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_dv   <= w_dv_set;
         r_ferr <= w_ferr_set;
         if ((r_state == ST_IDLE) || w_sample) r_cnt <= '0;
         else                                  r_cnt <= r_cnt + CW'(1);
         if (r_state == ST_START)              r_idx <= '0;
         else if (w_shift_en)                  r_idx <= r_idx + IDX_W'(1);
         if (w_shift_en) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
         if (w_dv_set)   r_dato  <= r_shift;
      end
   end

   assign dato = r_dato;
   assign dv   = r_dv;
   assign ferr = r_ferr;
   assign busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_rs232_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rs232_rx : directed and random frames against a sample-time   |
// |               model of the 8N1 receiver.                         |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module tb_rs232_rx;

   localparam int N   = 16;
   localparam int H   = N / 2;
   localparam int LAT = 2 + H + 9 * N + 1;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b1;
   logic [7:0] dato;
   logic       dv;
   logic       ferr;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int overlap  = 0;

   int         mon_dv_t[$];
   logic [7:0] mon_dv_d[$];
   int         mon_ferr_t[$];
   bit         busy_log[int];
   logic [7:0] exp_dato;

   rs232_rx #(.CLKS_PER_BIT(N)) dut (
      .clk   (clk),
      .reset (reset),
      .rx    (rx),
      .dato  (dato),
      .dv    (dv),
      .ferr  (ferr),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      busy_log[cyc] = busy;
      if (dv) begin
         mon_dv_t.push_back(cyc);
         mon_dv_d.push_back(dato);
      end
      if (ferr) mon_ferr_t.push_back(cyc);
      if (dv && ferr) overlap++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic clear_mon();
      mon_dv_t.delete();
      mon_dv_d.delete();
      mon_ferr_t.delete();
   endtask

   // Line level x cycles after the start edge, for a frame sent with bit period per.
   function automatic logic line_at(input int x, input logic [9:0] fr, input int per);
      int k;
      k = x / per;
      if (k >= 10) return 1'b1;
      return fr[k];
   endfunction

   // Receiver samples the port level at H + j*N after the start edge (j=1..8 data, 9 stop).
   task automatic model(input logic [7:0] b, input int per, input logic stopb,
                        output logic [7:0] rb, output logic st);
      logic [9:0] fr;
      fr = {stopb, b, 1'b0};
      for (int i = 0; i < 8; i++) rb[i] = line_at(H + (i + 1) * N, fr, per);
      st = line_at(H + 9 * N, fr, per);
   endtask

   // Caller is always #1 after a posedge; the start bit goes out in the current cycle.
   task automatic send_frame(input logic [7:0] b, input int per, input logic stopb, output int f);
      logic [9:0] fr;
      fr = {stopb, b, 1'b0};
      f  = cyc;
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         repeat (per) @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input string tag, input logic [7:0] b, input int per,
                            input logic stopb, input int hold, output int f);
      logic [7:0] eb;
      logic       es;
      model(b, per, stopb, eb, es);
      clear_mon();
      send_frame(b, per, stopb, f);
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1;
         check({tag, "_break_busy"}, busy, 1);
      end
      idle(20);
      if (es) begin
         check({tag, "_dv_cnt"},   mon_dv_t.size(), 1);
         check({tag, "_dv_time"},  (mon_dv_t.size() > 0) ? mon_dv_t[0] - f : -1, LAT);
         check({tag, "_dv_data"},  (mon_dv_d.size() > 0) ? mon_dv_d[0] : 8'hxx, eb);
         check({tag, "_ferr_cnt"}, mon_ferr_t.size(), 0);
         exp_dato = eb;
      end else begin
         check({tag, "_ferr_cnt"},  mon_ferr_t.size(), 1);
         check({tag, "_ferr_time"}, (mon_ferr_t.size() > 0) ? mon_ferr_t[0] - f : -1, LAT);
         check({tag, "_dv_cnt"},    mon_dv_t.size(), 0);
      end
      check({tag, "_dato"}, dato, exp_dato);
   endtask

   initial begin
      int f, f1, f2, nb, n81;
      logic [7:0] b;
      int per;

      repeat (3) @(posedge clk);
      #1;
      check("rst_dato", dato, 8'h00);
      check("rst_dv",   dv,   0);
      check("rst_ferr", ferr, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      exp_dato = 8'h00;
      idle(5);
      check("idle_busy", busy, 0);

      run_frame("t1_55", 8'h55, N, 1'b1, 0, f);
      check("t1_busy_before", busy_log[f + LAT - 1], 1);
      check("t1_busy_after",  busy_log[f + LAT + 1], 0);

      clear_mon();
      f  = cyc;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      idle(20);
      nb = 0;
      for (int c = f; c <= f + 20; c++) nb += busy_log[c];
      n_checks++;
      assert (nb <= 9) n_pass++;
      else $error("FAIL t2_busy_len: observed %0d expected <= 9", nb);
      check("t2_busy_low", busy_log[f + 12], 0);
      check("t2_dv_cnt",   mon_dv_t.size(), 0);
      check("t2_ferr_cnt", mon_ferr_t.size(), 0);
      run_frame("t2_3c", 8'h3C, N, 1'b1, 0, f);

      run_frame("t3_55", 8'h55, N, 1'b1, 0, f);
      run_frame("t3_a3", 8'hA3, N, 1'b0, 40, f);
      check("t3_dato_kept", dato, 8'h55);
      run_frame("t3_0f", 8'h0F, N, 1'b1, 0, f);

      clear_mon();
      send_frame(8'h00, N, 1'b1, f1);
      send_frame(8'hFF, N, 1'b1, f2);
      idle(20);
      check("t4_dv_cnt", mon_dv_t.size(), 2);
      if (mon_dv_t.size() == 2) begin
         check("t4_time0", mon_dv_t[0] - f1, LAT);
         check("t4_gap",   mon_dv_t[1] - mon_dv_t[0], 160);
         check("t4_d0",    mon_dv_d[0], 8'h00);
         check("t4_d1",    mon_dv_d[1], 8'hFF);
      end
      check("t4_ferr_cnt", mon_ferr_t.size(), 0);
      exp_dato = 8'hFF;

      clear_mon();
      fork
         send_frame(8'h81, N, 1'b1, f);
         begin
            repeat (88) @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            check("t5_rst_dato", dato, 8'h00);
            check("t5_rst_dv",   dv,   0);
            check("t5_rst_ferr", ferr, 0);
            check("t5_rst_busy", busy, 0);
         end
      join
      idle(200);
      n81 = 0;
      foreach (mon_dv_d[i]) if (mon_dv_d[i] == 8'h81) n81++;
      check("t5_no_81",    n81, 0);
      check("t5_ferr_cnt", mon_ferr_t.size(), 0);
      run_frame("t5_7e", 8'h7E, N, 1'b1, 0, f);

      run_frame("t6_c9_p15", 8'hC9, 15, 1'b1, 0, f);
      check("t6_c9_p15_val", dato, 8'hC9);
      idle(10);
      run_frame("t6_c9_p17", 8'hC9, 17, 1'b1, 0, f);
      check("t6_c9_p17_val", dato, 8'hC9);

      for (int k = 0; k < 10; k++) begin
         b   = 8'($urandom);
         per = ($urandom_range(0, 3) == 0) ? 15 + 2 * int'($urandom_range(0, 1)) : N;
         idle($urandom_range(0, 30));
         run_frame($sformatf("rnd%0d_p%0d", k, per), b, per, 1'b1, 0, f);
      end

      check("dv_ferr_overlap", overlap, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
